sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Responder for the core's inst/data SRAM-style request ports. Serializes both ports onto one AXI4-Lite-style master (single 64-bit beat per access), returns read data with synchronous-SRAM timing, and drives `stallreq_axi` into the pipeline controller until every presented request has completed.

## Interface

Parameters:
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width. Strobe width is `DATA_W/8`.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `inst_sram_en` / `data_sram_en`, input, 1: request presented.
- `inst_sram_we` / `data_sram_we`, input, 8: byte write enables. 0 means read.
- `inst_sram_addr` / `data_sram_addr`, input, ADDR_W: byte address.
- `inst_sram_wdata` / `data_sram_wdata`, input, DATA_W: write data.
- `inst_sram_rdata` / `data_sram_rdata`, output, DATA_W: registered read data.
- `stallreq_axi`, output, 1: freeze pipeline.
- `m_awaddr` / `m_araddr`, output, ADDR_W: address with bits [2:0] forced to 0.
- `m_awvalid` / `m_wvalid` / `m_arvalid`, output, 1: channel valid.
- `m_awready` / `m_wready` / `m_arready`, input, 1: channel ready.
- `m_wdata`, output, DATA_W: write data.
- `m_wstrb`, output, DATA_W/8: equals `we`.
- `m_bvalid` / `m_rvalid`, input, 1: response valid.
- `m_bready` / `m_rready`, output, 1: response ready.
- `m_bresp` / `m_rresp`, input, 2: response code.
- `m_rdata`, input, DATA_W: read data.

## Operation

- **FSM states:** IDLE, RD_A, RD_D, WR_AW (AW+W outstanding), WR_B.
- **Selection in IDLE:**
  - `data_pend = data_sram_en & ~data_done` takes priority over `inst_pend = inst_sram_en & ~inst_done`.
  - Inst is always a read.
  - The selected port's address, strobe and data are latched into a request register.
- **Read path:**
  - RD_A: `m_arvalid=1` until `m_arready`, then go to RD_D.
  - RD_D: `m_rready=1`. On `m_rvalid`, load the port's rdata register, set the port's done flag, and return to IDLE.
- **Write path:**
  - WR_AW: `m_awvalid` and `m_wvalid` both start at 1. Each drops independently on its own handshake. When both have handshaken, go to WR_B.
  - WR_B: `m_bready=1`. On `m_bvalid`, set `data_done` and return to IDLE.
- **Stall:** `stallreq_axi = inst_pend | data_pend`, combinational from inputs and done flags.
- **Done flags:**
  - Cleared in any cycle where `stallreq_axi=0`, i.e. the cycle the pipeline advances.
  - Clearing takes priority over nothing: a done flag cannot be set in the same cycle, because the FSM is IDLE and no completion can occur.
- **rdata hold:** each rdata register holds its value until that port's next read completes. Writes never alter `data_sram_rdata`.
- **Request stability:** the requester keeps en/addr/we/wdata stable while `stallreq_axi=1`. The bridge samples them only at IDLE selection.

## Timing

- **Reset values:**
  - State is IDLE.
  - All valid/ready outputs, done flags and rdata registers are 0.
  - `stallreq_axi` follows its combinational equation (0 when no en).
- **Minimum read latency:** selection at cycle 0 gives `m_arvalid` at cycle 1. With zero-wait ready/valid, rdata is updated at cycle 3 and `stallreq_axi` falls in the cycle rdata is valid.
- **Back-to-back access:** when both ports are pending, the inst request is selected in the IDLE cycle after data completes. There is no idle gap beyond that one cycle.
- **AXI rule:** valid, once asserted, never drops before its handshake. Address, data and strobe stay stable while valid.
- **Reset mid-transaction:** all channel valids and readies drop immediately, and any in-flight AXI transaction is abandoned. The system resets the interconnect on the same reset.

## Configuration

- `SRAM_AXI_BRIDGE_ERR_EN` defined:
  - Adds outputs `bus_err` (1 bit, sticky until reset) and `bus_err_addr` (ADDR_W).
  - On the first `m_bresp`/`m_rresp` != 0, set `bus_err` and capture the request address.
  - Later errors do not overwrite the captured address.
  - Read data is still returned.
- Undefined: responses are ignored and the ports are absent.

## Structure

- A shared package holds:
  - FSM state enum.
  - `AXI_RESP_OKAY`=2'b00.
  - Port select constants `SEL_INST`/`SEL_DATA`.
- One sub-module, `sram_axi_req_reg`: per-port done flag plus rdata register, instantiated twice.

## Test plan

- **Inst read only**, addr 0x8000_0004, slave returns 0x1122_3344_5566_7788 after 2 waits → `m_araddr`=0x8000_0000. `stallreq_axi` is high until the R beat, `inst_sram_rdata` = the value, and it holds afterwards.
- **Simultaneous inst read and data write** (we=0x0F, wdata=0xDEAD_BEEF) → AW/W issue first with wstrb=0x0F, then the AR for inst. `stallreq_axi` drops only after both complete.
- **Write with AW ready 3 cycles after W ready** → `m_wvalid` drops after its handshake, `m_awvalid` is held, and `m_bready` rises only after both handshakes.
- **Repeated en with the same addr after the advance cycle** → a new AR is issued (done cleared on the advance), not a stale completion.
- **`rst_n` asserted during RD_D** → all valids and readies go to 0 asynchronously, and after release the FSM is in IDLE with rdata=0.
- **Macro on, rresp=2'b10 at addr 0x100** → `bus_err`=1 and `bus_err_addr`=0x100. A following error at 0x200 leaves `bus_err_addr`=0x100.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-port to AXI4-Lite bridge.
package sram_axi_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_AW,
      ST_WR_B
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   localparam logic SEL_INST = 1'b0;
   localparam logic SEL_DATA = 1'b1;

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Single-beat AXI4-Lite-style channel bundle between bridge and interconnect.
interface sram_axi_bridge_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic [ADDR_W-1:0]   m_awaddr;
   logic                m_awvalid;
   logic                m_awready;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_wstrb;
   logic                m_wvalid;
   logic                m_wready;
   logic                m_bvalid;
   logic                m_bready;
   logic [1:0]          m_bresp;
   logic [ADDR_W-1:0]   m_araddr;
   logic                m_arvalid;
   logic                m_arready;
   logic                m_rvalid;
   logic                m_rready;
   logic [1:0]          m_rresp;
   logic [DATA_W-1:0]   m_rdata;

   modport master (
      output m_awaddr, m_awvalid,
      input  m_awready,
      output m_wdata, m_wstrb, m_wvalid,
      input  m_wready,
      input  m_bvalid, m_bresp,
      output m_bready,
      output m_araddr, m_arvalid,
      input  m_arready,
      input  m_rvalid, m_rresp, m_rdata,
      output m_rready
   );

   modport slave (
      input  m_awaddr, m_awvalid,
      output m_awready,
      input  m_wdata, m_wstrb, m_wvalid,
      output m_wready,
      output m_bvalid, m_bresp,
      input  m_bready,
      input  m_araddr, m_arvalid,
      output m_arready,
      output m_rvalid, m_rresp, m_rdata,
      input  m_rready
   );

endinterface

// File: rtl/sram_axi_req_reg.sv
// Per-port completion flag and registered read data.
module sram_axi_req_reg
   import sram_axi_bridge_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_set,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_rdata,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rdata
);

   logic              r_done;
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done  <= 1'b0;
         r_rdata <= '0;
      end else begin
         // set and clear never coincide: clear only happens while idle
         if (i_clr)
            r_done <= 1'b0;
         else if (i_set)
            r_done <= 1'b1;
         if (i_load)
            r_rdata <= i_rdata;
      end
   end

   assign o_done  = r_done;
   assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_axi_bridge.sv
// Serializes inst/data SRAM-style ports onto one single-beat AXI master.
// Optional SRAM_AXI_BRIDGE_ERR_EN adds sticky bus_err / bus_err_addr.
module sram_axi_bridge
   import sram_axi_bridge_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inst_sram_en,
   input  logic [DATA_W/8-1:0] inst_sram_we,
   input  logic [ADDR_W-1:0]   inst_sram_addr,
   input  logic [DATA_W-1:0]   inst_sram_wdata,
   output logic [DATA_W-1:0]   inst_sram_rdata,
   input  logic                data_sram_en,
   input  logic [DATA_W/8-1:0] data_sram_we,
   input  logic [ADDR_W-1:0]   data_sram_addr,
   input  logic [DATA_W-1:0]   data_sram_wdata,
   output logic [DATA_W-1:0]   data_sram_rdata,
   output logic                stallreq_axi,
`ifdef SRAM_AXI_BRIDGE_ERR_EN
   output logic                bus_err,
   output logic [ADDR_W-1:0]   bus_err_addr,
`endif
   sram_axi_bridge_if.master   m
);

   localparam int STRB_W = DATA_W / 8;

   state_e              r_state;
   logic                r_sel;
   logic [ADDR_W-1:0]   r_addr;
   logic [STRB_W-1:0]   r_strb;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_arvalid;
   logic                r_awvalid;
   logic                r_wvalid;
   logic                r_rready;
   logic                r_bready;

   logic                w_inst_done;
   logic                w_data_done;
   logic                w_inst_pend;
   logic                w_data_pend;
   logic                w_r_fire;
   logic                w_b_fire;
   logic                w_aw_ok;
   logic                w_w_ok;
   logic                w_inst_set;
   logic                w_data_rd;
   logic [ADDR_W-1:0]   w_addr_al;

   assign w_inst_pend  = inst_sram_en & ~w_inst_done;
   assign w_data_pend  = data_sram_en & ~w_data_done;
   assign stallreq_axi = w_inst_pend | w_data_pend;

   assign w_r_fire = r_rready & m.m_rvalid;
   assign w_b_fire = r_bready & m.m_bvalid;
   assign w_aw_ok  = ~r_awvalid | m.m_awready;
   assign w_w_ok   = ~r_wvalid | m.m_wready;

   assign w_inst_set = w_r_fire & (r_sel == SEL_INST);
   assign w_data_rd  = w_r_fire & (r_sel == SEL_DATA);
   assign w_addr_al  = {r_addr[ADDR_W-1:3], 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_sel     <= SEL_INST;
         r_addr    <= '0;
         r_strb    <= '0;
         r_wdata   <= '0;
         r_arvalid <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_rready  <= 1'b0;
         r_bready  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_data_pend) begin
                  r_sel   <= SEL_DATA;
                  r_addr  <= data_sram_addr;
                  r_strb  <= data_sram_we;
                  r_wdata <= data_sram_wdata;
                  if (|data_sram_we) begin
                     r_state   <= ST_WR_AW;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_state   <= ST_RD_A;
                     r_arvalid <= 1'b1;
                  end
               end else if (w_inst_pend) begin
                  r_sel     <= SEL_INST;
                  r_addr    <= inst_sram_addr;
                  r_strb    <= '0;
                  r_wdata   <= '0;
                  r_state   <= ST_RD_A;
                  r_arvalid <= 1'b1;
               end
            end
            ST_RD_A: begin
               if (m.m_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_D;
               end
            end
            ST_RD_D: begin
               if (m.m_rvalid) begin
                  r_rready <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            ST_WR_AW: begin
               // AW and W retire independently; B waits for both
               if (m.m_awready) r_awvalid <= 1'b0;
               if (m.m_wready)  r_wvalid  <= 1'b0;
               if (w_aw_ok && w_w_ok) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_WR_B;
               end
            end
            ST_WR_B: begin
               if (m.m_bvalid) begin
                  r_bready <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m.m_araddr  = w_addr_al;
   assign m.m_arvalid = r_arvalid;
   assign m.m_rready  = r_rready;
   assign m.m_awaddr  = w_addr_al;
   assign m.m_awvalid = r_awvalid;
   assign m.m_wdata   = r_wdata;
   assign m.m_wstrb   = r_strb;
   assign m.m_wvalid  = r_wvalid;
   assign m.m_bready  = r_bready;

   sram_axi_req_reg #(.DATA_W(DATA_W)) u_inst (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (~stallreq_axi),
      .i_set   (w_inst_set),
      .i_load  (w_inst_set),
      .i_rdata (m.m_rdata),
      .o_done  (w_inst_done),
      .o_rdata (inst_sram_rdata)
   );

   sram_axi_req_reg #(.DATA_W(DATA_W)) u_data (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (~stallreq_axi),
      .i_set   (w_data_rd | w_b_fire),
      .i_load  (w_data_rd),
      .i_rdata (m.m_rdata),
      .o_done  (w_data_done),
      .o_rdata (data_sram_rdata)
   );

`ifdef SRAM_AXI_BRIDGE_ERR_EN
   logic              r_bus_err;
   logic [ADDR_W-1:0] r_bus_err_addr;
   logic              w_err;

   assign w_err = (w_r_fire & (m.m_rresp != AXI_RESP_OKAY))
                | (w_b_fire & (m.m_bresp != AXI_RESP_OKAY));

   // first failing address is kept until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bus_err      <= 1'b0;
         r_bus_err_addr <= '0;
      end else if (w_err && !r_bus_err) begin
         r_bus_err      <= 1'b1;
         r_bus_err_addr <= r_addr;
      end
   end

   assign bus_err      = r_bus_err;
   assign bus_err_addr = r_bus_err_addr;
`else
   logic w_unused_resp;
   assign w_unused_resp = ^{m.m_rresp, m.m_bresp};
`endif

   // inst port is read-only; byte offset is dropped on the bus
   logic w_unused_in;
   assign w_unused_in = ^{inst_sram_we, inst_sram_wdata, r_addr[2:0]};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench: AXI slave model plus monitor checking bus beats and rdata.
module tb_sram_axi_bridge;

   typedef struct { logic [63:0] addr; int nb; } ar_t;
   typedef struct { logic [7:0] strb; logic [63:0] data; } w_t;
   typedef struct { logic [63:0] ird; logic [63:0] drd; int nr; int nb; } done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        inst_en, data_en, stall;
   logic [7:0]  inst_we, data_we;
   logic [63:0] inst_addr, data_addr, inst_wd, data_wd, inst_rd, data_rd;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
   logic        bus_err;
   logic [63:0] bus_err_addr;
`endif

   sram_axi_bridge_if #(.ADDR_W(64), .DATA_W(64)) axi ();

   sram_axi_bridge #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inst_sram_en    (inst_en),
      .inst_sram_we    (inst_we),
      .inst_sram_addr  (inst_addr),
      .inst_sram_wdata (inst_wd),
      .inst_sram_rdata (inst_rd),
      .data_sram_en    (data_en),
      .data_sram_we    (data_we),
      .data_sram_addr  (data_addr),
      .data_sram_wdata (data_wd),
      .data_sram_rdata (data_rd),
      .stallreq_axi    (stall),
`ifdef SRAM_AXI_BRIDGE_ERR_EN
      .bus_err         (bus_err),
      .bus_err_addr    (bus_err_addr),
`endif
      .m               (axi)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: got event expected none", nm);
   endtask

   // slave configuration
   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   logic [63:0] r_val = '0;
   logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;

   ar_t   exp_ar[$];
   logic [63:0] exp_aw[$];
   w_t    exp_w[$];
   done_t exp_done[$];

   logic [63:0] r_q[$];
   int ar_c, r_c, aw_c, w_c, b_c;
   int aw_n, w_n, b_iss, r_beats, b_beats;
   bit r_hs, b_hs;
   bit p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs, p_brdy;
   logic [63:0] p_araddr, p_awaddr, p_wdata;
   logic [7:0]  p_wstrb;

   initial begin
      axi.m_arready = 0; axi.m_awready = 0; axi.m_wready = 0;
      axi.m_rvalid = 0; axi.m_bvalid = 0;
      axi.m_rdata = '0; axi.m_rresp = 0; axi.m_bresp = 0;
      {ar_c, r_c, aw_c, w_c, b_c} = '0;
      {aw_n, w_n, b_iss, r_beats, b_beats} = '0;
      {r_hs, b_hs} = '0;
      {p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs, p_brdy} = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            axi.m_arready = 0; axi.m_awready = 0; axi.m_wready = 0;
            axi.m_rvalid = 0; axi.m_bvalid = 0;
            r_q.delete();
            {ar_c, r_c, aw_c, w_c, b_c} = '0;
            {r_hs, b_hs} = '0;
            aw_n = b_beats; w_n = b_beats; b_iss = b_beats;
            {p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs, p_brdy} = '0;
            continue;
         end
         // protocol: hold until handshake, drop right after
         if (p_arv && !p_arhs) begin
            chk("ar_hold", axi.m_arvalid, 1);
            chk("ar_addr_stable", axi.m_araddr, p_araddr);
         end
         if (p_awv && !p_awhs) begin
            chk("aw_hold", axi.m_awvalid, 1);
            chk("aw_addr_stable", axi.m_awaddr, p_awaddr);
         end
         if (p_wv && !p_whs) begin
            chk("w_hold", axi.m_wvalid, 1);
            chk("w_data_stable", axi.m_wdata, p_wdata);
            chk("w_strb_stable", axi.m_wstrb, p_wstrb);
         end
         if (p_arhs) chk("ar_drop", axi.m_arvalid, 0);
         if (p_awhs) chk("aw_drop", axi.m_awvalid, 0);
         if (p_whs)  chk("w_drop", axi.m_wvalid, 0);
         if (axi.m_bready && !p_brdy) begin
            chk("bready_after_aw", 64'(aw_n), 64'(b_beats + 1));
            chk("bready_after_w", 64'(w_n), 64'(b_beats + 1));
         end
         // advance cycle: compare returned data against scoreboard
         if ((inst_en || data_en) && !stall) begin
            if (exp_done.size() == 0) fail_now("done_unexpected");
            else begin
               done_t d;
               d = exp_done.pop_front();
               chk("inst_rdata", inst_rd, d.ird);
               chk("data_rdata", data_rd, d.drd);
               chk("r_beats_at_adv", 64'(r_beats), 64'(d.nr));
               chk("b_beats_at_adv", 64'(b_beats), 64'(d.nb));
            end
         end
         // slave responses
         if (r_hs) begin axi.m_rvalid = 0; r_hs = 0; end
         if (b_hs) begin axi.m_bvalid = 0; b_hs = 0; end
         if (!axi.m_rvalid && r_q.size() > 0) begin
            if (r_c >= r_wait) begin
               axi.m_rvalid = 1; axi.m_rdata = r_q.pop_front();
               axi.m_rresp = rresp_val; r_c = 0;
            end else r_c++;
         end
         if (!axi.m_bvalid && aw_n > b_iss && w_n > b_iss) begin
            if (b_c >= b_wait) begin
               axi.m_bvalid = 1; axi.m_bresp = bresp_val; b_iss++; b_c = 0;
            end else b_c++;
         end
         // slave address/data acceptance
         if (axi.m_arvalid) begin
            if (ar_c >= ar_wait) begin axi.m_arready = 1; ar_c = 0; end
            else begin axi.m_arready = 0; ar_c++; end
         end else begin axi.m_arready = 0; ar_c = 0; end
         if (axi.m_awvalid) begin
            if (aw_c >= aw_wait) begin axi.m_awready = 1; aw_c = 0; end
            else begin axi.m_awready = 0; aw_c++; end
         end else begin axi.m_awready = 0; aw_c = 0; end
         if (axi.m_wvalid) begin
            if (w_c >= w_wait) begin axi.m_wready = 1; w_c = 0; end
            else begin axi.m_wready = 0; w_c++; end
         end else begin axi.m_wready = 0; w_c = 0; end
         if (axi.m_arvalid && axi.m_arready) begin
            r_q.push_back(r_val);
            if (exp_ar.size() == 0) fail_now("ar_unexpected");
            else begin
               ar_t a;
               a = exp_ar.pop_front();
               chk("araddr", axi.m_araddr, a.addr);
               chk("ar_after_b", 64'(b_beats), 64'(a.nb));
            end
         end
         if (axi.m_awvalid && axi.m_awready) begin
            aw_n++;
            if (exp_aw.size() == 0) fail_now("aw_unexpected");
            else chk("awaddr", axi.m_awaddr, exp_aw.pop_front());
         end
         if (axi.m_wvalid && axi.m_wready) begin
            w_n++;
            if (exp_w.size() == 0) fail_now("w_unexpected");
            else begin
               w_t w;
               w = exp_w.pop_front();
               chk("wdata", axi.m_wdata, w.data);
               chk("wstrb", axi.m_wstrb, w.strb);
            end
         end
         if (axi.m_rvalid && axi.m_rready) begin r_hs = 1; r_beats++; end
         if (axi.m_bvalid && axi.m_bready) begin b_hs = 1; b_beats++; end
         p_arv = axi.m_arvalid; p_arhs = axi.m_arvalid && axi.m_arready;
         p_awv = axi.m_awvalid; p_awhs = axi.m_awvalid && axi.m_awready;
         p_wv = axi.m_wvalid; p_whs = axi.m_wvalid && axi.m_wready;
         p_brdy = axi.m_bready;
         p_araddr = axi.m_araddr; p_awaddr = axi.m_awaddr;
         p_wdata = axi.m_wdata; p_wstrb = axi.m_wstrb;
      end
   end

   task automatic issue(input bit ie, input logic [63:0] ia,
                        input bit de, input logic [7:0] dwe,
                        input logic [63:0] da, input logic [63:0] dwd,
                        input logic [63:0] rv);
      bit seen;
      @(posedge clk); #1;
      inst_en = ie; inst_addr = ia;
      data_en = de; data_we = dwe; data_addr = da; data_wd = dwd;
      r_val = rv;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!stall) begin seen = 1; break; end
      end
      if (!seen) fail_now("stall_timeout");
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      inst_en = 0; data_en = 0;
      repeat (n) @(posedge clk);
   endtask

   task automatic chk_bus_quiet(input string nm);
      chk({nm, "_arvalid"}, axi.m_arvalid, 0);
      chk({nm, "_awvalid"}, axi.m_awvalid, 0);
      chk({nm, "_wvalid"}, axi.m_wvalid, 0);
      chk({nm, "_rready"}, axi.m_rready, 0);
      chk({nm, "_bready"}, axi.m_bready, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      inst_en = 0; data_en = 0; inst_we = 0; data_we = 0;
      inst_addr = 0; data_addr = 0; inst_wd = 0; data_wd = 0;
      repeat (3) @(posedge clk); #1;
      chk_bus_quiet("reset");
      chk("reset_stall", stall, 0);
      chk("reset_inst_rdata", inst_rd, 0);
      chk("reset_data_rdata", data_rd, 0);
      rst_n = 1;

      // inst read, two AR waits
      ar_wait = 2;
      exp_ar.push_back('{64'h8000_0000, 0});
      exp_done.push_back('{64'h1122_3344_5566_7788, 64'h0, 1, 0});
      issue(1, 64'h8000_0004, 0, 0, 0, 0, 64'h1122_3344_5566_7788);
      idle(3);
      ar_wait = 0;
      chk("t1_inst_hold", inst_rd, 64'h1122_3344_5566_7788);
      chk("t1_stall_idle", stall, 0);

      // both ports: data write first, then inst read
      exp_aw.push_back(64'h8000_1008);
      exp_w.push_back('{8'h0F, 64'h0000_0000_DEAD_BEEF});
      exp_ar.push_back('{64'h8000_0010, 1});
      exp_done.push_back('{64'hA5A5_0000_0000_5A5A, 64'h0, 2, 1});
      issue(1, 64'h8000_0010, 1, 8'h0F, 64'h8000_1008,
            64'h0000_0000_DEAD_BEEF, 64'hA5A5_0000_0000_5A5A);
      idle(2);

      // AW accepted three cycles after W
      aw_wait = 3;
      exp_aw.push_back(64'h8000_2000);
      exp_w.push_back('{8'hFF, 64'h0123_4567_89AB_CDEF});
      exp_done.push_back('{64'hA5A5_0000_0000_5A5A, 64'h0, 2, 2});
      issue(0, 0, 1, 8'hFF, 64'h8000_2000, 64'h0123_4567_89AB_CDEF, 0);
      idle(2);
      aw_wait = 0;
      chk("t3_data_rdata_kept", data_rd, 0);

      // same data read re-presented across the advance cycle
      exp_ar.push_back('{64'h8000_3000, 2});
      exp_ar.push_back('{64'h8000_3000, 2});
      exp_done.push_back('{64'hA5A5_0000_0000_5A5A, 64'h0F0E_0D0C_0B0A_0908, 3, 2});
      exp_done.push_back('{64'hA5A5_0000_0000_5A5A, 64'h1111_2222_3333_4444, 4, 2});
      issue(0, 0, 1, 0, 64'h8000_3000, 0, 64'h0F0E_0D0C_0B0A_0908);
      issue(0, 0, 1, 0, 64'h8000_3000, 0, 64'h1111_2222_3333_4444);
      idle(2);

      // reset while waiting for R
      r_wait = 6;
      exp_ar.push_back('{64'h8000_0018, 2});
      @(posedge clk); #1;
      inst_en = 1; inst_addr = 64'h8000_0018; r_val = 64'h99;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (axi.m_rready) begin seen = 1; break; end
      end
      if (!seen) fail_now("t5_rready_timeout");
      #2 rst_n = 0;
      #1;
      chk_bus_quiet("t5_async");
      chk("t5_inst_rdata", inst_rd, 0);
      chk("t5_data_rdata", data_rd, 0);
      chk("t5_stall_en", stall, 1);
      inst_en = 0;
      #1 chk("t5_stall_off", stall, 0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1;
      r_wait = 0;
      repeat (3) @(posedge clk); #1;
      chk_bus_quiet("t5_after");
      chk("t5_after_inst_rdata", inst_rd, 0);

      // post-reset read with unaligned address
      exp_ar.push_back('{64'h8000_0008, 2});
      exp_done.push_back('{64'hCAFE_F00D_0000_0001, 64'h0, 5, 2});
      issue(1, 64'h8000_000F, 0, 0, 0, 0, 64'hCAFE_F00D_0000_0001);
      idle(2);

`ifdef SRAM_AXI_BRIDGE_ERR_EN
      chk("err_clear", bus_err, 0);
      rresp_val = 2'b10;
      exp_ar.push_back('{64'h100, 2});
      exp_done.push_back('{64'hCAFE_F00D_0000_0001, 64'h55, 6, 2});
      issue(0, 0, 1, 0, 64'h100, 0, 64'h55);
      idle(1);
      chk("err_set", bus_err, 1);
      chk("err_addr", bus_err_addr, 64'h100);
      exp_ar.push_back('{64'h200, 2});
      exp_done.push_back('{64'hCAFE_F00D_0000_0001, 64'h66, 7, 2});
      issue(0, 0, 1, 0, 64'h200, 0, 64'h66);
      idle(1);
      rresp_val = 2'b00;
      chk("err_sticky", bus_err, 1);
      chk("err_addr_kept", bus_err_addr, 64'h100);
`endif

      repeat (5) @(posedge clk);
      chk("drain_ar", 64'(exp_ar.size()), 0);
      chk("drain_aw", 64'(exp_aw.size()), 0);
      chk("drain_w", 64'(exp_w.size()), 0);
      chk("drain_done", 64'(exp_done.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
